m_seq_unit: RTL
===============

M_SEQ_UNIT -- requirements
Module: m_seq_unit

Interface
REQ-001 Parameter XLEN, default 32, operand and result width in bits.
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-high.
REQ-004 Port req_valid  input  1  request present.
REQ-005 Port req_ready  output  1  unit accepts a request this cycle.
REQ-006 Port req_op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 Port req_a  input  XLEN  operand rs1.
REQ-008 Port req_b  input  XLEN  operand rs2.
REQ-009 Port resp_valid  output  1  result present.
REQ-010 Port resp_ready  input  1  consumer takes the result.
REQ-011 Port resp_result  output  XLEN  selected result word.
REQ-012 Port busy  output  1  high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, CALC, DONE.
REQ-014 req_ready SHALL equal (state == IDLE); the request is accepted when req_valid && req_ready (cycle T).
REQ-015 On acceptance, op, sign flags, and operand magnitudes SHALL be registered; later input changes SHALL have no effect.
REQ-016 Normal ops: IDLE->CALC at T+1; CALC SHALL run exactly XLEN iterations (6-bit counter, 0..XLEN-1); CALC->DONE after the last iteration; resp_valid SHALL be high from cycle T+XLEN+1.
REQ-017 Multiply SHALL be iterative shift-add on magnitudes into a 2*XLEN product, negated at the end when the operand signs differ.
REQ-018 Signedness: MUL/MULH/DIV/REM treat a and b as signed; MULHSU treats a as signed and b as unsigned; MULHU/DIVU/REMU treat both as unsigned.
REQ-019 MUL SHALL return product[XLEN-1:0]; MULH/MULHSU/MULHU SHALL return product[2*XLEN-1:XLEN].
REQ-020 Divide SHALL be restoring radix-2 on magnitudes; quotient negated when signs differ; remainder takes the sign of the dividend.
REQ-021 Divide by zero SHALL go IDLE->DONE directly (resp_valid at T+1): DIV/DIVU = all-ones, REM/REMU = req_a.
REQ-022 Signed overflow (DIV/REM with a = 0x80000000, b = 0xFFFFFFFF) SHALL go IDLE->DONE directly: DIV = 0x80000000, REM = 0.
REQ-023 In DONE, resp_result SHALL stay stable while resp_valid && !resp_ready; DONE->IDLE on resp_ready.
REQ-024 A new request SHALL NOT be accepted in the cycle the response is consumed; the earliest acceptance is the following cycle.
REQ-025 resp_result SHALL be 0 whenever resp_valid is low.

Reset
REQ-026 On rst, the state SHALL go to IDLE, the counter and datapath registers to 0, resp_valid = 0, resp_result = 0, busy = 0, and req_ready = 1, immediately and asynchronously.
REQ-027 Reset asserted in CALC or DONE SHALL abort the operation; no response for it SHALL ever be issued.

Structure
REQ-028 Package m_pkg SHALL hold XLEN default, enum m_op_e (the eight funct3 codes), enum m_state_e (IDLE, CALC, DONE), and the constants DIV0_Q (all-ones) and OVF_DIVIDEND (0x80000000).
REQ-029 The shift-add / restoring-subtract iteration step plus its accumulator registers SHALL form the sub-module m_iter_core; m_seq_unit holds the FSM, handshake, sign handling and special cases.

Verification
REQ-030 MUL a=7, b=0xFFFFFFFD accepted at T -> resp_valid at T+33, result 0xFFFFFFEB.
REQ-031 MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
REQ-032 DIV and REM a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD (-3) and 0xFFFFFFFF (-1); DIVU and REMU a=100, b=0 -> 0xFFFFFFFF and 100 at T+1.
REQ-033 DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 at T+1; REM with the same operands -> 0.
REQ-034 Backpressure: resp_ready held low 5 cycles after resp_valid -> result stable, req_ready low, busy high; requests presented are not accepted.
REQ-035 rst pulsed at T+10 of a DIVU -> resp_valid stays 0 and req_ready is 1 after reset; the next request completes correctly.

Source files
------------

// File: rtl/m_pkg.sv
// Shared types and constants for the sequential RV32M multiply/divide unit.
package m_pkg;

   localparam int M_XLEN = 32;

   // RV32M funct3 encodings
   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } m_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } m_state_e;

   // Quotient returned for a division by zero
   localparam logic [M_XLEN-1:0] DIV0_Q       = {M_XLEN{1'b1}};
   // Most negative dividend; with a divisor of -1 it overflows
   localparam logic [M_XLEN-1:0] OVF_DIVIDEND = {1'b1, {(M_XLEN-1){1'b0}}};

endpackage

// File: rtl/m_iter_core.sv
// Iteration datapath: shift-add multiply or restoring radix-2 divide on
// unsigned magnitudes. The 2*XLEN accumulator holds {hi, lo}: for multiply
// it is the partial product with the multiplier in lo shifting out; for
// divide hi is the partial remainder and lo the dividend/quotient shifter.
module m_iter_core
   import m_pkg::*;
#(
   parameter int XLEN = M_XLEN
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic              step_i,
   input  logic              div_i,
   input  logic [XLEN-1:0]   a_mag_i,
   input  logic [XLEN-1:0]   b_mag_i,
   output logic [2*XLEN-1:0] acc_o,
   output logic [2*XLEN-1:0] acc_next_o
);

   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [XLEN:0]     mul_sum_s;
   logic [XLEN:0]     rem_sh_s;
   logic [XLEN:0]     diff_s;

   // Next accumulator value: load operands or perform one iteration
   always_comb begin
      acc_d     = acc_q;
      b_d       = b_q;
      mul_sum_s = {(XLEN+1){1'b0}};
      rem_sh_s  = {(XLEN+1){1'b0}};
      diff_s    = {(XLEN+1){1'b0}};
      if (load_i) begin
         acc_d = {{XLEN{1'b0}}, a_mag_i};
         b_d   = b_mag_i;
      end else if (step_i) begin
         if (div_i) begin
            // Bring in the next dividend bit and try to subtract the divisor
            rem_sh_s = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
            diff_s   = rem_sh_s - {1'b0, b_q};
            if (!diff_s[XLEN]) begin
               acc_d = {diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
               acc_d = {rem_sh_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end
         end else begin
            // Add the multiplicand when the current multiplier bit is set, then shift
            mul_sum_s = {1'b0, acc_q[2*XLEN-1:XLEN]}
                      + (acc_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
            acc_d     = {mul_sum_s, acc_q[XLEN-1:1]};
         end
      end else begin
         acc_d = acc_q;
      end
   end

   // Accumulator and divisor/multiplicand registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_q <= {(2*XLEN){1'b0}};
         b_q   <= {XLEN{1'b0}};
      end else begin
         acc_q <= acc_d;
         b_q   <= b_d;
      end
   end

   assign acc_o      = acc_q;
   assign acc_next_o = acc_d;

endmodule

// File: rtl/m_seq_unit.sv
// Sequential RV32M multiply/divide unit: request/response handshake, FSM,
// sign handling and the divide-by-zero / signed-overflow shortcuts.
module m_seq_unit
   import m_pkg::*;
#(
   parameter int XLEN = M_XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_op,
   input  logic [XLEN-1:0] req_a,
   input  logic [XLEN-1:0] req_b,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_result,
   output logic            busy
);

   m_state_e        state_q;
   logic [5:0]      cnt_q;
   m_op_e           op_q;
   logic            a_neg_q, b_neg_q;
   logic            resp_valid_q, req_ready_q, busy_q;
   logic [XLEN-1:0] resp_result_q;

   m_op_e             op_s;
   logic              a_signed_s, b_signed_s;
   logic              a_neg_s, b_neg_s;
   logic [XLEN-1:0]   a_mag_s, b_mag_s;
   logic              div0_s, ovf_s;
   logic [XLEN-1:0]   special_s;
   logic              load_s, step_s;
   logic [2*XLEN-1:0] acc_s, acc_next_s;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo_s, rem_s;
   logic [XLEN-1:0]   final_s;

   // Decode the incoming request: signedness, magnitudes, special cases
   always_comb begin
      op_s       = m_op_e'(req_op);
      a_signed_s = 1'b0;
      b_signed_s = 1'b0;
      special_s  = {XLEN{1'b0}};
      case (op_s)
         OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
            a_signed_s = 1'b1;
            b_signed_s = 1'b1;
         end
         OP_MULHSU: begin
            a_signed_s = 1'b1;
            b_signed_s = 1'b0;
         end
         default: begin
            a_signed_s = 1'b0;
            b_signed_s = 1'b0;
         end
      endcase
      a_neg_s = a_signed_s & req_a[XLEN-1];
      b_neg_s = b_signed_s & req_b[XLEN-1];
      a_mag_s = a_neg_s ? -req_a : req_a;
      b_mag_s = b_neg_s ? -req_b : req_b;
      div0_s  = req_op[2] & (req_b == {XLEN{1'b0}});
      ovf_s   = ((op_s == OP_DIV) || (op_s == OP_REM))
              && (req_a == OVF_DIVIDEND) && (req_b == DIV0_Q);
      if (div0_s) begin
         if (!req_op[1]) begin
            special_s = DIV0_Q;
         end else begin
            special_s = req_a;
         end
      end else if (ovf_s) begin
         if (op_s == OP_DIV) begin
            special_s = OVF_DIVIDEND;
         end else begin
            special_s = {XLEN{1'b0}};
         end
      end else begin
         special_s = {XLEN{1'b0}};
      end
   end

   assign load_s = (state_q == IDLE) && req_valid;
   assign step_s = (state_q == CALC);

   m_iter_core #(.XLEN(XLEN)) u_core (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (load_s),
      .step_i     (step_s),
      .div_i      (op_q[2]),
      .a_mag_i    (a_mag_s),
      .b_mag_i    (b_mag_s),
      .acc_o      (acc_s),
      .acc_next_o (acc_next_s)
   );

   // Sign-correct the accumulator after the final iteration and pick the result word
   always_comb begin
      prod_s  = (a_neg_q ^ b_neg_q) ? -acc_next_s : acc_next_s;
      quo_s   = (a_neg_q ^ b_neg_q) ? -acc_next_s[XLEN-1:0] : acc_next_s[XLEN-1:0];
      rem_s   = a_neg_q ? -acc_next_s[2*XLEN-1:XLEN] : acc_next_s[2*XLEN-1:XLEN];
      final_s = {XLEN{1'b0}};
      case (op_q)
         OP_MUL:                       final_s = prod_s[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: final_s = prod_s[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              final_s = quo_s;
         OP_REM, OP_REMU:              final_s = rem_s;
         default:                      final_s = {XLEN{1'b0}};
      endcase
   end

   // Control FSM with registered handshake and result outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= 6'd0;
         op_q          <= OP_MUL;
         a_neg_q       <= 1'b0;
         b_neg_q       <= 1'b0;
         resp_valid_q  <= 1'b0;
         resp_result_q <= {XLEN{1'b0}};
         req_ready_q   <= 1'b1;
         busy_q        <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  op_q        <= op_s;
                  a_neg_q     <= a_neg_s;
                  b_neg_q     <= b_neg_s;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  cnt_q       <= 6'd0;
                  if (div0_s || ovf_s) begin
                     state_q       <= DONE;
                     resp_valid_q  <= 1'b1;
                     resp_result_q <= special_s;
                  end else begin
                     state_q <= CALC;
                  end
               end
            end
            CALC: begin
               if (cnt_q == 6'(XLEN-1)) begin
                  state_q       <= DONE;
                  cnt_q         <= 6'd0;
                  resp_valid_q  <= 1'b1;
                  resp_result_q <= final_s;
               end else begin
                  cnt_q <= cnt_q + 6'd1;
               end
            end
            DONE: begin
               if (resp_ready) begin
                  state_q       <= IDLE;
                  resp_valid_q  <= 1'b0;
                  resp_result_q <= {XLEN{1'b0}};
                  req_ready_q   <= 1'b1;
                  busy_q        <= 1'b0;
               end
            end
            default: begin
               state_q       <= IDLE;
               cnt_q         <= 6'd0;
               resp_valid_q  <= 1'b0;
               resp_result_q <= {XLEN{1'b0}};
               req_ready_q   <= 1'b1;
               busy_q        <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready   = req_ready_q;
   assign resp_valid  = resp_valid_q;
   assign resp_result = resp_result_q;
   assign busy        = busy_q;

endmodule
